// File: rtl/tff_ctrl_pkg.sv
// Shared types for the toggle-cell sequencer: command opcodes and FSM states.
package tff_ctrl_pkg;

  // Command opcodes as carried on cmd_op
  typedef enum logic [1:0] {
    OP_UP    = 2'b00,
    OP_DOWN  = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Up/down commands consume a step count; load/clear complete in one RUN cycle
  function automatic logic is_step_op(input op_e op);
    return (op == OP_UP) || (op == OP_DOWN);
  endfunction

endpackage

// File: rtl/tff_bank.sv
// Bank of WIDTH T-flip-flop cells. Each cell flips when its toggle input is
// high; a low clr_n at a clock edge forces every cell to 0.
module tff_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] t_vec,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      // One toggle cell: clear dominates, otherwise q ^= t
      always_ff @(posedge clk) begin
        if (!clr_n) begin
          q_reg[gi] <= 1'b0;
        end else begin
          q_reg[gi] <= q_reg[gi] ^ t_vec[gi];
        end
      end
    end
  endgenerate

  assign q = q_reg;

endmodule

// File: rtl/tff_count_ctrl.sv
// Sequencer for a bank of toggle cells. Accepts up/down/load/clear commands on
// a valid/ready handshake, drives the per-bit toggle vector while in RUN, and
// pulses done for one cycle when the command completes.
module tff_count_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic             hold,
  output logic [WIDTH-1:0] t_vec,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  state_e           state_reg, state_next;
  op_e              op_reg, op_next;
  logic [WIDTH-1:0] arg_reg, arg_next;
  logic [WIDTH-1:0] remaining_reg, remaining_next;

  // Ripple-carry style toggle masks: a bit flips when all lower bits are
  // ones (counting up) or all lower bits are zeros (counting down).
  logic [WIDTH-1:0] up_t, dn_t;

  assign up_t[0] = 1'b1;
  assign dn_t[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_carry
      assign up_t[gi] = up_t[gi-1] & q[gi-1];
      assign dn_t[gi] = dn_t[gi-1] & ~q[gi-1];
    end
  endgenerate

  // Toggle vector: only non-zero while RUN, not held, and work remains
  always_comb begin
    t_vec = '0;
    if (state_reg == RUN && !hold) begin
      case (op_reg)
        OP_UP:    if (remaining_reg != '0) t_vec = up_t;
        OP_DOWN:  if (remaining_reg != '0) t_vec = dn_t;
        OP_LOAD:  t_vec = q ^ arg_reg;
        OP_CLEAR: t_vec = q;
        default:  t_vec = '0;
      endcase
    end
  end

  // Next-state logic: command capture, step counting and completion
  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    arg_next       = arg_reg;
    remaining_next = remaining_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          op_next        = op_e'(cmd_op);
          arg_next       = cmd_arg;
          remaining_next = is_step_op(op_e'(cmd_op)) ? cmd_arg : '0;
          state_next     = RUN;
        end
      end
      RUN: begin
        if (!hold) begin
          if (is_step_op(op_reg) && remaining_reg != '0) begin
            remaining_next = remaining_reg - {{(WIDTH-1){1'b0}}, 1'b1};
          end else begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Controller registers; reset abandons any command in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      op_reg        <= OP_UP;
      arg_reg       <= '0;
      remaining_reg <= '0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      arg_reg       <= arg_next;
      remaining_reg <= remaining_next;
    end
  end

  assign cmd_ready = (state_reg == IDLE);
  assign busy      = (state_reg == RUN) || (state_reg == DONE);
  assign done      = (state_reg == DONE);

  tff_bank #(
    .WIDTH (WIDTH)
  ) u_bank (
    .clk   (clk),
    .clr_n (rst_n),
    .t_vec (t_vec),
    .q     (q)
  );

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Directed testbench for tff_count_ctrl with hand-computed expectations.
module tb_tff_count_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_arg;
  logic             hold;
  logic [WIDTH-1:0] t_vec;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;

  int errors = 0;
  int checks = 0;

  tff_count_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .hold      (hold),
    .t_vec     (t_vec),
    .q         (q),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one command for one cycle starting at a negedge while IDLE;
  // returns at the negedge of the first RUN cycle.
  task automatic send_cmd(input logic [1:0] op, input logic [WIDTH-1:0] arg);
    cmd_op    = op;
    cmd_arg   = arg;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    $display("cmd op=%0d arg=%02h accepted, q=%02h", op, arg, q);
  endtask

  task automatic test_reset;
    // state straight after power-on reset
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got=%02h exp=00", q); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
    checks++; if (t_vec !== 8'h00) begin errors++; $display("FAIL reset_tvec got=%02h exp=00", t_vec); end
    // reset in the middle of an up-count
    send_cmd(2'b00, 8'd5);
    repeat (2) @(negedge clk);
    checks++; if (q !== 8'h02) begin errors++; $display("FAIL midrun_q got=%02h exp=02", q); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL abort_q got=%02h exp=00", q); end
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL abort_ready_busy got=%b%b exp=10", cmd_ready, busy); end
    begin
      int seen = 0;
      for (int i = 0; i < 5; i++) begin
        if (done === 1'b1) seen++;
        @(negedge clk);
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
    end
    $display("test_reset done, q=%02h", q);
  endtask

  task automatic test_up;
    logic [WIDTH-1:0] exp_t [5];
    exp_t[0] = 8'h01; exp_t[1] = 8'h03; exp_t[2] = 8'h01; exp_t[3] = 8'h07; exp_t[4] = 8'h01;
    send_cmd(2'b00, 8'd5);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (t_vec !== exp_t[i] || busy !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL up_step%0d got t=%02h busy=%b done=%b exp t=%02h busy=1 done=0", i, t_vec, busy, done, exp_t[i]);
      end
      @(negedge clk);
    end
    checks++; if (t_vec !== 8'h00 || q !== 8'h05 || done !== 1'b0) begin errors++; $display("FAIL up_last_run got t=%02h q=%02h done=%b exp t=00 q=05 done=0", t_vec, q, done); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL up_done got done=%b busy=%b ready=%b exp 1 1 0", done, busy, cmd_ready); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL up_idle got done=%b busy=%b ready=%b exp 0 0 1", done, busy, cmd_ready); end
    $display("test_up done, q=%02h", q);
  endtask

  task automatic test_down;
    int pulses;
    // clear the 0x05 left by the previous test
    send_cmd(2'b11, 8'h00);
    checks++; if (t_vec !== 8'h05) begin errors++; $display("FAIL pre_clear_tvec got=%02h exp=05", t_vec); end
    repeat (2) @(negedge clk);
    send_cmd(2'b01, 8'd2);
    checks++; if (t_vec !== 8'hFF) begin errors++; $display("FAIL down_t0 got=%02h exp=FF", t_vec); end
    @(negedge clk);
    checks++; if (q !== 8'hFF || t_vec !== 8'h01) begin errors++; $display("FAIL down_wrap got q=%02h t=%02h exp q=FF t=01", q, t_vec); end
    @(negedge clk);
    checks++; if (q !== 8'hFE || t_vec !== 8'h00) begin errors++; $display("FAIL down_final got q=%02h t=%02h exp q=FE t=00", q, t_vec); end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL down_done_count got=%0d exp=1", pulses); end
    $display("test_down done, q=%02h", q);
  endtask

  task automatic test_load_clear;
    send_cmd(2'b10, 8'h3C);
    checks++; if (t_vec !== 8'hC2) begin errors++; $display("FAIL load3c_tvec got=%02h exp=C2", t_vec); end
    repeat (2) @(negedge clk);
    checks++; if (q !== 8'h3C) begin errors++; $display("FAIL load3c_q got=%02h exp=3C", q); end
    send_cmd(2'b10, 8'hA5);
    checks++; if (t_vec !== 8'h99) begin errors++; $display("FAIL loada5_tvec got=%02h exp=99", t_vec); end
    @(negedge clk);
    checks++; if (q !== 8'hA5 || done !== 1'b1 || t_vec !== 8'h00) begin errors++; $display("FAIL loada5_done got q=%02h done=%b t=%02h exp q=A5 done=1 t=00", q, done, t_vec); end
    @(negedge clk);
    send_cmd(2'b11, 8'h5A);
    checks++; if (t_vec !== 8'hA5) begin errors++; $display("FAIL clear_tvec got=%02h exp=A5", t_vec); end
    @(negedge clk);
    checks++; if (q !== 8'h00 || done !== 1'b1) begin errors++; $display("FAIL clear_done got q=%02h done=%b exp q=00 done=1", q, done); end
    @(negedge clk);
    // load of the current value: zero toggles, still completes
    send_cmd(2'b10, 8'h00);
    checks++; if (t_vec !== 8'h00 || busy !== 1'b1) begin errors++; $display("FAIL load_same got t=%02h busy=%b exp t=00 busy=1", t_vec, busy); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || q !== 8'h00) begin errors++; $display("FAIL load_same_done got done=%b q=%02h exp 1 00", done, q); end
    @(negedge clk);
    $display("test_load_clear done, q=%02h", q);
  endtask

  task automatic test_hold;
    int done_cyc;
    done_cyc = -1;
    send_cmd(2'b00, 8'd3);
    // cycle counter c: 1 = first RUN cycle; hold high in cycles 2..5
    for (int c = 1; c <= 20; c++) begin
      hold = (c >= 2 && c <= 5);
      #1;
      if (hold) begin
        checks++;
        if (q !== 8'h01 || t_vec !== 8'h00) begin
          errors++; $display("FAIL hold_c%0d got q=%02h t=%02h exp q=01 t=00", c, q, t_vec);
        end
      end
      if (done === 1'b1) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
    end
    hold = 1'b0;
    checks++; if (done_cyc != 9) begin errors++; $display("FAIL hold_done_cycle got=%0d exp=9", done_cyc); end
    checks++; if (q !== 8'h03) begin errors++; $display("FAIL hold_final_q got=%02h exp=03", q); end
    @(negedge clk);
    $display("test_hold done, q=%02h done_cycle=%0d", q, done_cyc);
  endtask

  task automatic test_zero_and_ignore;
    // up with arg=0, cmd_valid left high with a different command behind it
    cmd_op = 2'b00; cmd_arg = 8'h00; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_op = 2'b10; cmd_arg = 8'h77;
    checks++; if (cmd_ready !== 1'b0 || t_vec !== 8'h00 || busy !== 1'b1) begin errors++; $display("FAIL zero_run got ready=%b t=%02h busy=%b exp 0 00 1", cmd_ready, t_vec, busy); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || cmd_ready !== 1'b0 || q !== 8'h03) begin errors++; $display("FAIL zero_done got done=%b ready=%b q=%02h exp 1 0 03", done, cmd_ready, q); end
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || q !== 8'h03) begin errors++; $display("FAIL ignore_idle got ready=%b busy=%b q=%02h exp 1 0 03", cmd_ready, busy, q); end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++; if (busy !== 1'b1 || t_vec !== 8'h74) begin errors++; $display("FAIL second_accept got busy=%b t=%02h exp 1 74", busy, t_vec); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || q !== 8'h77) begin errors++; $display("FAIL second_done got done=%b q=%02h exp 1 77", done, q); end
    @(negedge clk);
    $display("test_zero_and_ignore done, q=%02h", q);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_arg   = '0;
    hold      = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_up();
    test_down();
    test_load_clear();
    test_hold();
    test_zero_and_ignore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
